// File: rtl/riscv_pkg.sv
// Shared types and defaults for the pipeline control slice.
package riscv_pkg;

  // Control FSM states for the two-stage (FD / MW) pipeline controller.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2
  } pipe_ctrl_state_e;

  // Default number of cycles to wait for a data-memory ack before a bus error.
  localparam int MEM_TIMEOUT_DEF = 16;

  // Width of the memory wait counter; wide enough for any timeout up to 255.
  localparam int WAIT_W = 8;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/handshake bundle between the pipeline datapath and its controller.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);

  // Datapath -> controller
  logic             load_use_i;
  logic             dmem_req_i;
  logic             dmem_ack_i;
  logic             br_taken_i;
  logic             is_mret_i;
  logic             irq_pending_i;
  logic             cnt_clr_i;

  // Controller -> datapath / CSR file
  logic             stall_fd_o;
  logic             stall_mw_o;
  logic             flush_fd_o;
  logic             flush_mw_o;
  logic             trap_take_o;
  logic             bus_err_o;
  logic [CNT_W-1:0] stall_cnt_o;

  // Datapath side: raises hazards and memory handshake, obeys stall/flush.
  modport master (
    output load_use_i, dmem_req_i, dmem_ack_i, br_taken_i, is_mret_i,
           irq_pending_i, cnt_clr_i,
    input  stall_fd_o, stall_mw_o, flush_fd_o, flush_mw_o, trap_take_o,
           bus_err_o, stall_cnt_o
  );

  // Controller side.
  modport slave (
    input  load_use_i, dmem_req_i, dmem_ack_i, br_taken_i, is_mret_i,
           irq_pending_i, cnt_clr_i,
    output stall_fd_o, stall_mw_o, flush_fd_o, flush_mw_o, trap_take_o,
           bus_err_o, stall_cnt_o
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear, else increment unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/trap controller for a two-stage (FD, MW) RISC-V pipeline.
// Mealy outputs from the registered state and the current hazard inputs.
module pipeline_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  pipeline_ctrl_if.slave bus
);

  localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(MEM_TIMEOUT);

  pipe_ctrl_state_e  state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              ld_done_q, ld_done_d;

  logic              stall_fd, stall_mw, flush_fd, flush_mw, trap_take, bus_err;
  logic [CNT_W-1:0]  stall_cnt;

  // State, memory wait counter and load-use bubble flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      ld_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ld_done_q  <= ld_done_d;
    end
  end

  // Next-state logic. ld_done stays set for as long as the load-use case is
  // the selected RUN case, so a hazard held high by the stalled FD stage
  // produces a single bubble; any other cycle re-arms it.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ld_done_d  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.dmem_req_i && !bus.dmem_ack_i) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else if (bus.irq_pending_i) begin
          state_d = TRAP;
        end else if (bus.br_taken_i || bus.is_mret_i) begin
          state_d = RUN;
        end else if (bus.load_use_i) begin
          ld_done_d = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Ack wins over timeout; hazards/irq are held by the stalled stages.
        if (bus.dmem_ack_i) begin
          state_d = RUN;
        end else if (wait_cnt_q < TIMEOUT_C) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
          state_d = TRAP;
        end
      end
      TRAP: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Output decode; everything forced low while reset is asserted.
  always_comb begin
    stall_fd  = 1'b0;
    stall_mw  = 1'b0;
    flush_fd  = 1'b0;
    flush_mw  = 1'b0;
    trap_take = 1'b0;
    bus_err   = 1'b0;
    if (rst_ni) begin
      unique case (state_q)
        RUN: begin
          if (bus.dmem_req_i && !bus.dmem_ack_i) begin
            stall_fd = 1'b1;
            stall_mw = 1'b1;
          end else if (bus.irq_pending_i) begin
            trap_take = 1'b1;
            flush_fd  = 1'b1;
            flush_mw  = 1'b1;
          end else if (bus.br_taken_i || bus.is_mret_i) begin
            flush_fd = 1'b1;
          end else if (bus.load_use_i && !ld_done_q) begin
            stall_fd = 1'b1;
            flush_mw = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!bus.dmem_ack_i) begin
            if (wait_cnt_q < TIMEOUT_C) begin
              stall_fd = 1'b1;
              stall_mw = 1'b1;
            end else begin
              bus_err   = 1'b1;
              trap_take = 1'b1;
              flush_fd  = 1'b1;
              flush_mw  = 1'b1;
            end
          end
        end
        TRAP: begin
          flush_fd = 1'b1;
        end
        default: begin
          flush_fd = 1'b0;
        end
      endcase
    end
  end

  // Performance counter of FD stall cycles.
  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (stall_fd),
    .clr_i  (bus.cnt_clr_i),
    .cnt_o  (stall_cnt)
  );

  assign bus.stall_fd_o  = stall_fd;
  assign bus.stall_mw_o  = stall_mw;
  assign bus.flush_fd_o  = flush_fd;
  assign bus.flush_mw_o  = flush_mw;
  assign bus.trap_take_o = trap_take;
  assign bus.bus_err_o   = bus_err;
  assign bus.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. A second instance with a 2-bit counter
// exercises counter saturation on the same stimulus.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(16)) bus  ();
  pipeline_ctrl_if #(.CNT_W(2))  bus2 ();

  pipeline_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  pipeline_ctrl #(.MEM_TIMEOUT(16), .CNT_W(2)) dut_sat (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus2)
  );

  // Input codes: {load_use, dmem_req, dmem_ack, br_taken, is_mret, irq, cnt_clr}
  localparam logic [6:0] IDLE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1000000;
  localparam logic [6:0] DR   = 7'b0100000;
  localparam logic [6:0] DA   = 7'b0010000;
  localparam logic [6:0] BR   = 7'b0001000;
  localparam logic [6:0] MR   = 7'b0000100;
  localparam logic [6:0] IRQ  = 7'b0000010;
  localparam logic [6:0] CLR  = 7'b0000001;

  // Output codes: {stall_fd, stall_mw, flush_fd, flush_mw, trap_take, bus_err}
  localparam logic [5:0] O_NONE  = 6'b000000;
  localparam logic [5:0] O_STALL = 6'b110000;
  localparam logic [5:0] O_BUB   = 6'b100100;
  localparam logic [5:0] O_FFD   = 6'b001000;
  localparam logic [5:0] O_TRAP  = 6'b001110;
  localparam logic [5:0] O_BERR  = 6'b001111;

  task automatic drive(input logic [6:0] v);
    {bus.load_use_i, bus.dmem_req_i, bus.dmem_ack_i, bus.br_taken_i,
     bus.is_mret_i, bus.irq_pending_i, bus.cnt_clr_i} = v;
    {bus2.load_use_i, bus2.dmem_req_i, bus2.dmem_ack_i, bus2.br_taken_i,
     bus2.is_mret_i, bus2.irq_pending_i, bus2.cnt_clr_i} = v;
  endtask

  function automatic logic [5:0] outs();
    return {bus.stall_fd_o, bus.stall_mw_o, bus.flush_fd_o, bus.flush_mw_o,
            bus.trap_take_o, bus.bus_err_o};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive(LU | DR | IRQ | BR);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (outs() !== O_NONE) begin
        $display("FAIL reset_outs cyc%0d: got %b want %b", i, outs(), O_NONE);
        n_err++;
      end
      n_vec++;
      if (bus.stall_cnt_o !== 16'd0 || bus2.stall_cnt_o !== 2'd0) begin
        $display("FAIL reset_cnt cyc%0d: got %0d/%0d want 0/0", i, bus.stall_cnt_o, bus2.stall_cnt_o);
        n_err++;
      end
    end
    @(negedge clk);
    drive(IDLE);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (outs() !== O_NONE) begin
      $display("FAIL reset_release: got %b want %b", outs(), O_NONE);
      n_err++;
    end
  endtask

  task automatic test_load_use();
    logic [6:0] iv [7] = '{CLR, LU, LU, LU, IDLE, LU, IDLE};
    logic [5:0] ev [7] = '{O_NONE, O_BUB, O_NONE, O_NONE, O_NONE, O_BUB, O_NONE};
    int         ec [7] = '{-1, 0, 1, 1, 1, 1, 2};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(iv[i]);
      #1;
      n_vec++;
      if (outs() !== ev[i]) begin
        $display("FAIL load_use cyc%0d: got %b want %b", i, outs(), ev[i]);
        n_err++;
      end
      if (ec[i] >= 0) begin
        n_vec++;
        if (bus.stall_cnt_o !== 16'(ec[i])) begin
          $display("FAIL load_use_cnt cyc%0d: got %0d want %0d", i, bus.stall_cnt_o, ec[i]);
          n_err++;
        end
      end
    end
  endtask

  task automatic test_mem_ack();
    // Hazard/branch raised mid-wait must be ignored; req+ack in RUN never stalls.
    logic [6:0] iv [8] = '{CLR, DR, DR, DR | LU | BR, DR, DR | DA, DR | DA, IDLE};
    logic [5:0] ev [8] = '{O_NONE, O_STALL, O_STALL, O_STALL, O_STALL, O_NONE, O_NONE, O_NONE};
    int         ec [8] = '{-1, 0, 1, 2, 3, 4, 4, 4};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(iv[i]);
      #1;
      n_vec++;
      if (outs() !== ev[i]) begin
        $display("FAIL mem_ack cyc%0d: got %b want %b", i, outs(), ev[i]);
        n_err++;
      end
      if (ec[i] >= 0) begin
        n_vec++;
        if (bus.stall_cnt_o !== 16'(ec[i])) begin
          $display("FAIL mem_ack_cnt cyc%0d: got %0d want %0d", i, bus.stall_cnt_o, ec[i]);
          n_err++;
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [6:0] v;
    logic [5:0] e;
    logic [1:0] e_sat;
    for (int i = 0; i < 20; i++) begin
      if (i == 0)       v = CLR;
      else if (i < 18)  v = DR;
      else if (i == 18) v = DR | IRQ | BR;
      else              v = IDLE;
      if (i == 0)       e = O_NONE;
      else if (i <= 16) e = O_STALL;
      else if (i == 17) e = O_BERR;
      else if (i == 18) e = O_FFD;
      else              e = O_NONE;
      @(negedge clk);
      drive(v);
      #1;
      n_vec++;
      if (outs() !== e) begin
        $display("FAIL timeout cyc%0d: got %b want %b", i, outs(), e);
        n_err++;
      end
      if (i >= 1) begin
        e_sat = (i - 1 >= 3) ? 2'd3 : 2'(i - 1);
        n_vec++;
        if (bus2.stall_cnt_o !== e_sat) begin
          $display("FAIL sat_cnt cyc%0d: got %0d want %0d", i, bus2.stall_cnt_o, e_sat);
          n_err++;
        end
      end
    end
    n_vec++;
    if (bus.stall_cnt_o !== 16'd16) begin
      $display("FAIL timeout_cnt: got %0d want 16", bus.stall_cnt_o);
      n_err++;
    end
  endtask

  task automatic test_irq_branch();
    logic [6:0] iv [12] = '{CLR, IRQ | BR, IDLE, BR, MR, IDLE, DR | IRQ, DA, IDLE,
                            LU | BR, LU, IDLE};
    logic [5:0] ev [12] = '{O_NONE, O_TRAP, O_FFD, O_FFD, O_FFD, O_NONE, O_STALL, O_NONE,
                            O_NONE, O_FFD, O_BUB, O_NONE};
    int         ec [12] = '{-1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(iv[i]);
      #1;
      n_vec++;
      if (outs() !== ev[i]) begin
        $display("FAIL irq_branch cyc%0d: got %b want %b", i, outs(), ev[i]);
        n_err++;
      end
      if (ec[i] >= 0) begin
        n_vec++;
        if (bus.stall_cnt_o !== 16'(ec[i])) begin
          $display("FAIL irq_branch_cnt cyc%0d: got %0d want %0d", i, bus.stall_cnt_o, ec[i]);
          n_err++;
        end
      end
    end
  endtask

  task automatic test_irq_in_wait();
    logic [6:0] iv [8] = '{CLR, DR, DR | IRQ, DR | IRQ, DR | DA | IRQ, IRQ, IDLE, IDLE};
    logic [5:0] ev [8] = '{O_NONE, O_STALL, O_STALL, O_STALL, O_NONE, O_TRAP, O_FFD, O_NONE};
    int         ec [8] = '{-1, 0, 1, 2, 3, 3, 3, 3};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(iv[i]);
      #1;
      n_vec++;
      if (outs() !== ev[i]) begin
        $display("FAIL irq_in_wait cyc%0d: got %b want %b", i, outs(), ev[i]);
        n_err++;
      end
      if (ec[i] >= 0) begin
        n_vec++;
        if (bus.stall_cnt_o !== 16'(ec[i])) begin
          $display("FAIL irq_in_wait_cnt cyc%0d: got %0d want %0d", i, bus.stall_cnt_o, ec[i]);
          n_err++;
        end
      end
    end
  endtask

  task automatic test_cnt_clr();
    // Clear in a stall cycle wins over the increment.
    logic [6:0] iv [5] = '{IDLE, DR | CLR, DR | DA, LU | CLR, IDLE};
    logic [5:0] ev [5] = '{O_NONE, O_STALL, O_NONE, O_BUB, O_NONE};
    int         ec [5] = '{-1, -1, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(iv[i]);
      #1;
      n_vec++;
      if (outs() !== ev[i]) begin
        $display("FAIL cnt_clr cyc%0d: got %b want %b", i, outs(), ev[i]);
        n_err++;
      end
      if (ec[i] >= 0) begin
        n_vec++;
        if (bus.stall_cnt_o !== 16'(ec[i])) begin
          $display("FAIL cnt_clr_cnt cyc%0d: got %0d want %0d", i, bus.stall_cnt_o, ec[i]);
          n_err++;
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    // Reset asserted in cycles 3-4; in cycle 6 a branch must flush (RUN), not stall.
    logic [6:0] iv [9] = '{CLR, DR, DR, DR, DR | IRQ, IDLE, BR, LU, IDLE};
    logic [5:0] ev [9] = '{O_NONE, O_STALL, O_STALL, O_NONE, O_NONE, O_NONE, O_FFD, O_BUB, O_NONE};
    int         ec [9] = '{-1, 0, 1, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(iv[i]);
      rst_n = !(i == 3 || i == 4);
      #1;
      n_vec++;
      if (outs() !== ev[i]) begin
        $display("FAIL reset_mid_wait cyc%0d: got %b want %b", i, outs(), ev[i]);
        n_err++;
      end
      if (ec[i] >= 0) begin
        n_vec++;
        if (bus.stall_cnt_o !== 16'(ec[i])) begin
          $display("FAIL reset_mid_wait_cnt cyc%0d: got %0d want %0d", i, bus.stall_cnt_o, ec[i]);
          n_err++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_ack();
    test_timeout();
    test_irq_branch();
    test_irq_in_wait();
    test_cnt_clr();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: max wait cycles for a data-memory ack before a bus error (range 2..255).
REQ-002 Parameter CNT_W, default 16: stall performance counter width.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 load_use_i  input  1  load-use RAW hazard between the execute and MW stages.
REQ-006 dmem_req_i  input  1  MW-stage instruction accesses data memory.
REQ-007 dmem_ack_i  input  1  data memory completes the access this cycle.
REQ-008 br_taken_i  input  1  resolved taken branch or jump.
REQ-009 is_mret_i  input  1  mret in the MW stage.
REQ-010 irq_pending_i  input  1  enabled interrupt pending, already qualified by the CSR file.
REQ-011 cnt_clr_i  input  1  synchronous clear of the stall counter.
REQ-012 stall_fd_o  output  1  hold the FD pipeline register.
REQ-013 stall_mw_o  output  1  hold the MW pipeline register.
REQ-014 flush_fd_o  output  1  squash the FD register contents.
REQ-015 flush_mw_o  output  1  insert a bubble into the MW register.
REQ-016 trap_take_o  output  1  one-cycle pulse telling the CSR file to save mepc/mcause and redirect to mtvec.
REQ-017 bus_err_o  output  1  one-cycle pulse on a memory timeout.
REQ-018 stall_cnt_o  output  CNT_W  saturating count of cycles with stall_fd_o=1.

Function
REQ-019 The FSM SHALL have three states: RUN, MEM_WAIT and TRAP. Outputs are Mealy, derived from the registered state and the current inputs.
REQ-020 RUN handles its cases in this priority order, and only the highest active case applies:
(a) dmem_req_i=1 and dmem_ack_i=0: stall_fd_o=1, stall_mw_o=1; next state MEM_WAIT; wait counter cleared to 1.
(b) irq_pending_i=1: trap_take_o=1, flush_fd_o=1, flush_mw_o=1; next state TRAP.
(c) br_taken_i=1 or is_mret_i=1: flush_fd_o=1; next state RUN.
(d) load_use_i=1 and ld_done=0: stall_fd_o=1, flush_mw_o=1; ld_done is set to 1.
(e) Otherwise all control outputs are 0.
REQ-021 ld_done SHALL be a register that is cleared on every cycle that is not case (d). A load-use hazard therefore inserts exactly one bubble even if load_use_i stays high.
REQ-022 In MEM_WAIT with dmem_ack_i=0 and the wait counter below MEM_TIMEOUT: stall_fd_o=1, stall_mw_o=1; the counter increments.
REQ-023 In MEM_WAIT with dmem_ack_i=1: all stalls are 0 in that same cycle; next state RUN. Ack takes priority over timeout when both occur in the same cycle.
REQ-024 In MEM_WAIT with the counter equal to MEM_TIMEOUT and no ack: bus_err_o=1, trap_take_o=1, flush_fd_o=1, flush_mw_o=1; next state TRAP.
REQ-025 irq_pending_i, br_taken_i, is_mret_i and load_use_i SHALL be ignored in MEM_WAIT. Branches, mret and hazards are taken after return to RUN, because the stalled stages hold them.
REQ-026 TRAP lasts exactly one cycle: flush_fd_o=1, all other outputs 0, all inputs ignored; next state RUN.
REQ-027 stall_cnt_o SHALL increment by 1 on every cycle with stall_fd_o=1 and saturate at all-ones. When cnt_clr_i=1 it is cleared instead, which takes priority over the increment.
REQ-028 trap_take_o and bus_err_o SHALL never be high on consecutive cycles.

Reset
REQ-029 While rst_ni=0, every output SHALL be 0 regardless of inputs, the state SHALL be RUN, and ld_done, the wait counter and stall_cnt_o SHALL be 0.
REQ-030 Reset asserted mid-MEM_WAIT or mid-TRAP SHALL abort it immediately. The first cycle after release is a RUN cycle.

Structure
REQ-031 The pipe_ctrl_state_e enum and the default MEM_TIMEOUT value SHALL live in riscv_pkg.
REQ-032 The stall counter SHALL be one sub-module, sat_counter, parameterised by width, with inc/clr inputs.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- load_use_i high for 3 cycles in RUN -> stall_fd_o=1 and flush_mw_o=1 in the first cycle only; stall_cnt_o=1.
- dmem_req_i=1 with dmem_ack_i after 4 cycles -> stalls high for 4 cycles, low in the ack cycle; stall_cnt_o=4.
- dmem_req_i=1 with no ack, MEM_TIMEOUT=16 -> bus_err_o and trap_take_o pulse once; a TRAP cycle with flush_fd_o=1 follows; then RUN.
- irq_pending_i and br_taken_i raised together in RUN -> trap_take_o=1 and both flushes high; the next cycle shows flush_fd_o only.
- irq_pending_i raised during MEM_WAIT -> no trap until the ack; trap_take_o fires the cycle after return to RUN.
- rst_ni pulled low mid-MEM_WAIT -> all outputs 0 immediately; stall_cnt_o=0; normal operation after release.
